// File: rtl/simon_key_expander.sv
// SIMON 64/128 key schedule: expands a 128-bit master key into ROUNDS round-key words and
// streams them, one per cycle, into the write port of the round-key BRAM.
module simon_key_expander #(
    parameter int unsigned ROUNDS = 44,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [127:0]      key,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_di
);

    typedef enum logic [1:0] {StIdle, StLoad, StExpand, StFin} state_e;

    // Bit 61 holds z3 index 0 (leftmost character of the sequence).
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROUNDS - 1);
    localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(3);

    state_e      state;
    logic [31:0] w0, w1, w2, w3;
    logic [5:0]  zidx;
    logic [5:0]  zidx_next;
    logic [31:0] tmp_a, tmp_b, k_next;

    always_comb begin
        tmp_a     = {w3[2:0], w3[31:3]} ^ w1;
        tmp_b     = tmp_a ^ {tmp_a[0], tmp_a[31:1]};
        k_next    = 32'hFFFF_FFFC ^ {31'b0, Z3[6'd61 - zidx]} ^ w0 ^ tmp_b;
        zidx_next = (zidx == 6'd61) ? 6'd0 : zidx + 6'd1;
    end

    assign bram_we = bram_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            bram_di   <= '0;
            w0        <= '0;
            w1        <= '0;
            w2        <= '0;
            w3        <= '0;
            zidx      <= '0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        w0        <= key[31:0];
                        w1        <= key[63:32];
                        w2        <= key[95:64];
                        w3        <= key[127:96];
                        zidx      <= '0;
                        busy      <= 1'b1;
                        bram_en   <= 1'b1;
                        bram_addr <= '0;
                        bram_di   <= key[31:0];
                        state     <= StLoad;
                    end
                end
                StLoad: begin
                    bram_addr <= bram_addr + 1'b1;
                    if (bram_addr == LOAD_LAST) begin
                        // Window still holds k0..k3 here, so k4 is computed from it directly.
                        bram_di <= k_next;
                        w0      <= w1;
                        w1      <= w2;
                        w2      <= w3;
                        w3      <= k_next;
                        zidx    <= zidx_next;
                        state   <= StExpand;
                    end else begin
                        case (bram_addr[1:0])
                            2'd0:    bram_di <= w1;
                            2'd1:    bram_di <= w2;
                            default: bram_di <= w3;
                        endcase
                    end
                end
                StExpand: begin
                    if (bram_addr == LAST_ADDR) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        bram_en   <= 1'b0;
                        bram_addr <= '0;
                        bram_di   <= '0;
                        state     <= StFin;
                    end else begin
                        bram_addr <= bram_addr + 1'b1;
                        bram_di   <= k_next;
                        w0        <= w1;
                        w1        <= w2;
                        w2        <= w3;
                        w3        <= k_next;
                        zidx      <= zidx_next;
                    end
                end
                StFin: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_key_expander.sv
// Bench for simon_key_expander: random and directed keys checked cycle by cycle against a
// word-array model of the SIMON 64/128 key schedule, for ROUNDS=44 and ROUNDS=66.
module tb_simon_key_expander;

    localparam logic [127:0] STD_KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;

    logic         clk = 1'b0;
    logic         rst, start, sel;
    logic [127:0] key;
    logic         a_busy, a_done, a_en, a_we, b_busy, b_done, b_en, b_we;
    logic [6:0]   a_addr, b_addr;
    logic [31:0]  a_di, b_di;
    logic         o_busy, o_done, o_en, o_we;
    logic [6:0]   o_addr;
    logic [31:0]  o_di;
    logic [31:0]  ref_w [0:65];
    int           n_vec = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    simon_key_expander #(.ROUNDS(44), .ADDR_W(7)) u_dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .key(key),
        .busy(a_busy), .done(a_done), .bram_en(a_en), .bram_we(a_we),
        .bram_addr(a_addr), .bram_di(a_di)
    );

    simon_key_expander #(.ROUNDS(66), .ADDR_W(7)) u_dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .key(key),
        .busy(b_busy), .done(b_done), .bram_en(b_en), .bram_we(b_we),
        .bram_addr(b_addr), .bram_di(b_di)
    );

    always_comb begin
        o_busy = sel ? b_busy : a_busy;
        o_done = sel ? b_done : a_done;
        o_en   = sel ? b_en   : a_en;
        o_we   = sel ? b_we   : a_we;
        o_addr = sel ? b_addr : a_addr;
        o_di   = sel ? b_di   : a_di;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int r);
        return (x >> r) | (x << (32 - r));
    endfunction

    task automatic gen_ref(input logic [127:0] k, input int n);
        logic [61:0] zc;
        logic [31:0] tmp;
        zc = 62'b11011011101011000110010111100000010010001010011100110100001111;
        for (int i = 0; i < 4; i++) ref_w[i] = k[32*i +: 32];
        for (int i = 4; i < n; i++) begin
            tmp = ror32(ref_w[i-1], 3) ^ ref_w[i-3];
            tmp = tmp ^ ror32(tmp, 1);
            ref_w[i] = 32'hFFFF_FFFC ^ {31'b0, zc[61 - ((i - 4) % 62)]} ^ ref_w[i-4] ^ tmp;
        end
    endtask

    // Starts a run with key k (start driven now, seen at the next rising edge) and checks every
    // cycle through the done pulse. spur1/spur2: cycles to pulse a stray start with a junk key.
    // rst_at > 0: assert rst during the write of that address and check the run is killed.
    task automatic run_once(input logic [127:0] k, input int spur1, input int spur2,
                            input int rst_at);
        int n;
        n = sel ? 66 : 44;
        gen_ref(k, n);
        key   = k;
        start = 1'b1;
        for (int j = 1; j <= n + 1; j++) begin
            @(negedge clk);
            start = (j == spur1) || (j == spur2);
            if (j == 1 || start) key = {$urandom, $urandom, $urandom, $urandom};
            if (rst_at > 0 && j == rst_at + 2) begin
                check_eq("rst_mid_outputs", 64'({o_busy, o_done, o_en, o_we}), 64'(0));
                rst = 1'b0;
                for (int q = 0; q < 50; q++) begin
                    @(negedge clk);
                    check_eq("rst_mid_quiet", 64'({o_busy, o_done, o_en}), 64'(0));
                end
                return;
            end
            if (j <= n) begin
                check_eq("addr", 64'(o_addr), 64'(j - 1));
                check_eq("di", 64'(o_di), 64'(ref_w[j-1]));
                check_eq("en_we_busy_done", 64'({o_en, o_we, o_busy, o_done}), 64'(4'b1110));
                if (k == STD_KEY && !sel && j == 5)
                    check_eq("std_k4", 64'(o_di), 64'(32'h70A0_11C3));
            end else begin
                check_eq("done_cycle", 64'({o_en, o_we, o_busy, o_done}), 64'(4'b0001));
            end
            if (rst_at > 0 && j == rst_at + 1) rst = 1'b1;
        end
    endtask

    task automatic gap_cycle();
        @(negedge clk);
        check_eq("idle_after_run", 64'({o_busy, o_done, o_en, o_we}), 64'(0));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        key   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("reset_idle_a", 64'({a_busy, a_done, a_en, a_we, a_addr, a_di}), 64'(0));
            check_eq("reset_idle_b", 64'({b_busy, b_done, b_en, b_we, b_addr, b_di}), 64'(0));
        end

        run_once(STD_KEY, 0, 0, 0);
        gap_cycle();
        run_once(STD_KEY, 10, 30, 0);
        gap_cycle();
        run_once(STD_KEY, 0, 0, 20);
        run_once(STD_KEY, 0, 0, 0);

        // Back-to-back: start in the done cycle must be ignored, one cycle later accepted.
        start = 1'b1;
        key   = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        check_eq("b2b_start_ignored", 64'({o_busy, o_done, o_en}), 64'(0));
        run_once(key, 0, 0, 0);
        gap_cycle();

        for (int r = 0; r < 4; r++) begin
            run_once({$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);
            gap_cycle();
        end

        sel = 1'b1;
        @(negedge clk);
        run_once('0, 0, 0, 0);
        gap_cycle();
        run_once({$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);
        gap_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/simon_key_expander.md
Name: simon_key_expander

Overview:
- Generates the 44 SIMON 64/128 round keys from a 128-bit master key.
- Writes them, one word per cycle, into the round-key BRAM (write side of the 44x32 key store).
- The cipher datapath reads the store after `done`.
- The port names on the BRAM side match the key store's en/we/addr/di interface, so the ports connect one-to-one.

Parameters:
- ROUNDS, 44, number of round keys generated and written (4 master words + ROUNDS-4 expanded words); must be 5..66.
- ADDR_W, 7, width of the BRAM word address.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin expansion; sampled only in IDLE.
- key  input  128  master key: key[31:0]=k0, key[63:32]=k1, key[95:64]=k2, key[127:96]=k3.
- busy  output  1  high from the cycle after accepted start through the last write.
- done  output  1  one-cycle pulse the cycle after the last BRAM write.
- bram_en  output  1  BRAM enable; high only on write cycles.
- bram_we  output  1  BRAM write enable; equal to bram_en.
- bram_addr  output  ADDR_W  round-key index being written.
- bram_di  output  32  round-key word being written.

Behaviour:
- Reset state of all outputs is 0: busy, done, bram_en, bram_we, bram_addr, bram_di. FSM goes to IDLE. Window registers and counters are cleared.
- FSM states are IDLE, LOAD, EXPAND, FIN.
  - IDLE: on start=1, capture key into a 4-word window w0..w3 (w0=k0). Clear addr counter. Go to LOAD.
  - LOAD: 4 cycles, writing k0..k3 to addresses 0..3. Go to EXPAND after address 3.
  - EXPAND: ROUNDS-4 cycles, writing k[i] to address i for i=4..ROUNDS-1. Go to FIN after address ROUNDS-1.
  - FIN: done=1 for one cycle, busy=0. Return to IDLE.
- Expansion per cycle, with all arithmetic mod 2^32 and rotations within 32 bits:
  - tmp = ROR3(w3) ^ w1.
  - tmp = tmp ^ ROR1(tmp).
  - k[i] = 0xFFFFFFFC ^ z3[(i-4) mod 62] ^ w0 ^ tmp.
  - The window then shifts: w0<=w1, w1<=w2, w2<=w3, w3<=k[i].
- z3 is the 62-bit constant 11011011101011000110010111100000010010001010011100110100001111. Index 0 is the leftmost character. It is held as a ROM constant with a 6-bit index counter that wraps 61->0.
- Write timing:
  - Outputs are registered; bram_en/we/addr/di are valid together on the write cycle.
  - Accepted start at edge T gives the address 0 write at cycle T+1 and the address ROUNDS-1 write at T+ROUNDS.
  - done is high at T+ROUNDS+1, giving exactly ROUNDS write cycles.
- Writes are contiguous, with no gaps or repeated addresses. bram_en=0 on every non-write cycle.
- start while busy or during FIN is ignored, with no restart and no capture.
- key is sampled only at the accepted start; later changes have no effect on the current run.
- rst mid-run takes priority over everything. The next cycle is in IDLE with bram_en=0 and no further writes. BRAM contents written so far are left as is.
- rst and start together: reset wins and start is dropped.
- Back-to-back runs: start asserted in the cycle done is high is ignored because the FSM is in FIN. start one cycle later is accepted.

Test Plan:
- Reset, idle: assert rst 3 cycles with start=0 -> all outputs 0 for 10 cycles, no BRAM writes.
- Standard vector: key=0x1b1a1918_13121110_0b0a0908_03020100, one-cycle start -> writes at addr 0..3 of 0x03020100, 0x0b0a0908, 0x13121110, 0x1b1a1918. Addr 4 = 0x70A011C3. Exactly 44 writes to addr 0..43; done pulses once, 45 cycles after start. All 44 words match the bench reference model.
- start ignored while busy: pulse start again at cycles 10 and 30 with a different key -> write sequence and done timing are identical to the standard vector.
- Reset mid-run: assert rst at the addr 20 write cycle -> no write to addr >= 21, done never pulses, busy=0 next cycle. A new start then produces the full standard sequence.
- z-index wrap: ROUNDS=66, key all zeros -> addr 65 uses z3 index 61. Bench model matches all 66 words; done 67 cycles after start.
- Back-to-back: start in the done cycle is ignored; start one cycle later is accepted -> second run of 44 writes begins 1 cycle after acceptance.
